// File: rtl/gnn_pkg.sv
// Shared types and constants for the GNN job controller.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package gnn_pkg;

  localparam int NUM_WEIGHTS = 24;
  localparam int W_WIDTH     = 5;
  localparam int NOM_LATENCY = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    ERR   = 2'd3
  } ctrl_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_TIMEOUT  = 2'd1,
    ERR_SPURIOUS = 2'd2,
    ERR_OVERFLOW = 2'd3
  } err_code_t;

  // Bank index of weight w_src,dst: layer 0 covers w0..3 -> w4..7,
  // layer 1 covers w4..7 -> w8..9 and sits above the 16 layer-0 entries.
  function automatic logic [4:0] weight_idx(input logic layer,
                                            input logic [3:0] src,
                                            input logic [3:0] dst);
    int idx;
    if (!layer) idx = 4 * (int'(dst) - 4) + int'(src);
    else        idx = 16 + 4 * (int'(dst) - 8) + (int'(src) - 4);
    return 5'(idx);
  endfunction

endpackage

// File: rtl/gnn_job_ctrl_tag_fifo.sv
// In-flight tag FIFO holding {tag, issue timestamp} per outstanding job.
// Latency: head is the oldest entry, visible the cycle after its push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               din,
  output logic [WIDTH-1:0]               head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop is evaluated first so a full FIFO can take a push in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // An overflowing push would silently lose a job tag.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/gnn_job_ctrl.sv
// Job scheduler and weight-bank controller for the 4-node 2-layer GNN datapath.
// Latency: dp_in_ready 1 cycle after job accept; res_valid 1 cycle after dp_out_ready.
// Backpressure: job_ready drops at MAX_INFLIGHT or outside READY; wr_ready drops while jobs are in flight.
module gnn_job_ctrl
  import gnn_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int TAG_W        = 4,
  parameter int TIMEOUT      = 16,
  parameter int TS_W         = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_valid,
  output logic                                wr_ready,
  input  logic [4:0]                          wr_addr,
  input  logic [W_WIDTH-1:0]                  wr_data,
  input  logic                                cfg_commit,
  output logic                                weights_valid,
  output logic [NUM_WEIGHTS*W_WIDTH-1:0]      w_bank,
  input  logic                                job_valid,
  input  logic [TAG_W-1:0]                    job_tag,
  output logic                                job_ready,
  output logic                                dp_in_ready,
  input  logic                                dp_out_ready,
  output logic                                res_valid,
  output logic [TAG_W-1:0]                    res_tag,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]   inflight,
  output logic                                err,
  output logic [1:0]                          err_code
);

  localparam int ENT_W = TAG_W + TS_W;

  ctrl_state_t                          state, state_nxt;
  err_code_t                            err_code_q;
  logic [NUM_WEIGHTS-1:0][W_WIDTH-1:0]  bank;
  logic [TS_W-1:0]                      ts_now, head_ts, age;
  logic [TAG_W-1:0]                     head_tag;
  logic [ENT_W-1:0]                     head;
  logic                                 fifo_full, fifo_empty, armed;
  logic                                 in_err, wr_acc, job_acc;
  logic                                 to_err, sp_err, err_now, push, pop;

  assign in_err   = (state == ERR);
  assign wr_acc   = wr_valid && wr_ready;
  assign job_acc  = job_valid && job_ready;
  assign {head_tag, head_ts} = head;
  assign age      = ts_now - head_ts;

  // Completions before the first post-reset issue belong to discarded jobs.
  assign to_err   = !in_err && !fifo_empty && (age > TS_W'(TIMEOUT));
  assign sp_err   = !in_err && armed && dp_out_ready && fifo_empty;
  assign err_now  = to_err || sp_err;
  assign push     = job_acc && !err_now;
  assign pop      = dp_out_ready && !fifo_empty && !in_err && !err_now;
  assign w_bank   = bank;
  assign err_code = err_code_q;

  tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (ENT_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({job_tag, ts_now}),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (inflight)
  );

  // Next state and handshake readies; a write with commit in LOAD ends in READY.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    job_ready = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = fifo_empty;
        if (wr_valid && fifo_empty) state_nxt = LOAD;
      end
      LOAD: begin
        wr_ready = fifo_empty;
        if (cfg_commit) state_nxt = READY;
      end
      READY: begin
        wr_ready  = fifo_empty;
        job_ready = !fifo_full;
        if (wr_valid && fifo_empty) state_nxt = LOAD;
      end
      default: state_nxt = ERR;
    endcase
    if (err_now) state_nxt = ERR;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Weight bank and commit flag; out-of-range addresses are accepted but dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank          <= '0;
      weights_valid <= 1'b0;
    end else begin
      if (wr_acc) begin
        weights_valid <= 1'b0;
        if (wr_addr < 5'(NUM_WEIGHTS)) bank[wr_addr] <= wr_data;
      end
      if (state == LOAD && cfg_commit) weights_valid <= 1'b1;
    end
  end

  // Timestamp, issue pulse and result pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_now      <= '0;
      armed       <= 1'b0;
      dp_in_ready <= 1'b0;
      res_valid   <= 1'b0;
      res_tag     <= '0;
    end else begin
      ts_now      <= ts_now + 1'b1;
      dp_in_ready <= push;
      res_valid   <= pop;
      if (push) armed   <= 1'b1;
      if (pop)  res_tag <= head_tag;
    end
  end

  // Sticky error capture; only the first error is recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
    end else if (err_now) begin
      err <= 1'b1;
      if (to_err) err_code_q <= ERR_TIMEOUT;
      else        err_code_q <= ERR_SPURIOUS;
    end
  end

endmodule

// File: doc/gnn_job_ctrl.md
Name: gnn_job_ctrl

Overview:
- Job scheduler and weight-configuration controller for the 4-node, 2-layer GNN inference datapath.
- Holds the 24-entry, 5-bit signed weight bank: w04..w37 for layer 1 and w48..w79 for the output layer.
- Issues one-cycle `in_ready` pulses to the pipelined datapath, tracks in-flight jobs by tag and matches each datapath output-ready pulse back to its tag.
- Blocks weight changes while jobs are in flight and flags lost or spurious completions.

Parameters:
- `MAX_INFLIGHT`, 4: maximum outstanding jobs; also the tag FIFO depth (power of 2).
- `TAG_W`, 4: width of the job tag.
- `TIMEOUT`, 16: maximum cycles from issue to completion for the oldest job (nominal datapath latency is 5).
- `TS_W`, 6: width of the free-running timestamp; must satisfy 2^TS_W > TIMEOUT.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `wr_valid` in 1: weight write request.
- `wr_ready` out 1: weight write accepted this cycle.
- `wr_addr` in 5: weight index 0..23. Index = 4*j + i for layer-1 weight w_i,(4+j). Index = 16 + 4*k + i for output weight w_(4+i),(8+k).
- `wr_data` in 5: signed weight value.
- `cfg_commit` in 1: pulse that ends a load and makes the weights valid.
- `weights_valid` out 1: weight bank is committed.
- `w_bank` out 120: flattened weights; entry n occupies bits [5n+4:5n].
- `job_valid` in 1: job request.
- `job_tag` in TAG_W: tag for the job.
- `job_ready` out 1: job accepted when `job_valid` && `job_ready`.
- `dp_in_ready` out 1: start pulse to the datapath.
- `dp_out_ready` in 1: completion pulse from the datapath (any one node-ready bit).
- `res_valid` out 1: one-cycle result pulse.
- `res_tag` out TAG_W: tag of the completed job.
- `inflight` out $clog2(MAX_INFLIGHT+1): number of outstanding jobs.
- `err` out 1: sticky error flag.
- `err_code` out 2: 0 = none, 1 = timeout, 2 = spurious completion, 3 = tag FIFO overflow (assertion only).

Behaviour:
- Reset values: all 24 weights = 0; state = IDLE; `weights_valid`, `job_ready`, `dp_in_ready`, `res_valid`, `err` = 0; `res_tag`, `err_code`, `inflight`, FIFO pointers, timestamp = 0.
- A reset asserted mid-operation discards all in-flight tags. Completions that arrive afterwards are ignored until the first post-reset issue. The bench masks `dp_out_ready` for 8 cycles after reset.
- States and transitions:
  - IDLE -> LOAD on an accepted write.
  - LOAD -> READY on `cfg_commit`.
  - READY -> LOAD on an accepted write.
  - Any state -> ERR on an error condition; only `rst` leaves ERR.
  - `cfg_commit` in IDLE or READY is ignored.
- Weight writes:
  - `wr_ready` = (state is IDLE, LOAD or READY) && `inflight` == 0.
  - The bank entry updates on the accepting edge.
  - `wr_addr` > 23 is accepted and dropped.
  - The first accepted write clears `weights_valid` in the same edge. `cfg_commit` sets it.
  - If `wr_valid` and `cfg_commit` arrive in the same cycle in LOAD: the write lands first, then the commit is taken, giving READY with the new value.
- Job issue:
  - `job_ready` = (state == READY) && (`inflight` < MAX_INFLIGHT), combinational.
  - On accept, tag and current timestamp are pushed to the FIFO.
  - `dp_in_ready` = 1 in the cycle after accept (registered), for exactly 1 cycle. Back-to-back accepts give back-to-back pulses.
- Completion:
  - `dp_out_ready` with `inflight` > 0 pops the FIFO head.
  - `res_valid` = 1 and `res_tag` = head tag in the next cycle.
  - There is no backpressure on results.
- `inflight` arithmetic per edge: +1 on accept, -1 on completion, unchanged if both occur in the same cycle. An accept and a completion in the same cycle with `inflight` == MAX_INFLIGHT cannot happen, because `job_ready` is 0 at full.
- Timeout check:
  - Runs every cycle with `inflight` > 0: age = (ts_now - head_ts) mod 2^TS_W.
  - age > TIMEOUT -> ERR, `err_code` = 1.
- Spurious completion: `dp_out_ready` with `inflight` == 0 -> ERR, `err_code` = 2.
- The first error wins; `err_code` holds until reset.
- In ERR: `job_ready`, `wr_ready` and `dp_in_ready` = 0, FIFO frozen, `w_bank` held.
- The timestamp counter wraps freely.

Decomposition:
- Package `gnn_pkg`:
  - Constants: `NUM_WEIGHTS`=24, `W_WIDTH`=5, `NOM_LATENCY`=5.
  - Enum `ctrl_state_t` {IDLE, LOAD, READY, ERR}.
  - Enum `err_code_t`.
  - Function computing the weight index from (layer, src, dst).
- Sub-module `tag_fifo`: synchronous FIFO, DEPTH = MAX_INFLIGHT, width TAG_W + TS_W, with push, pop, full, empty and head outputs. Supports push and pop in the same cycle when full (pop-first semantics).

Test Plan:
- Config: write idx 0..23 with values (idx mod 16) - 8, then `cfg_commit` -> `weights_valid`=1; `w_bank[4:0]`=-8 and `w_bank[119:115]`=-1; state READY.
- Single job: tag 0xA accepted at cycle t -> `dp_in_ready` high at t+1 only; `dp_out_ready` at t+6 -> `res_valid` and `res_tag`=0xA at t+7; `inflight` returns to 0.
- Saturation: present 6 jobs back-to-back (tags 1..6) with completion 5 cycles after each issue -> `job_ready` drops after 4 accepts; results appear in order 1,2,3,4,5,6; `inflight` never exceeds 4; simultaneous accept and completion keeps `inflight` constant.
- Config lock: `wr_valid` while `inflight`=2 -> `wr_ready`=0 and the bank is unchanged; after both jobs complete, the write is accepted, `weights_valid`=0 and `job_ready`=0 until commit.
- Timeout: issue tag 3 and withhold `dp_out_ready` -> `err`=1 with `err_code`=1 exactly 17 cycles after issue; then `job_ready`=0 and `wr_ready`=0; `rst` restores reset values.
- Spurious completion: `dp_out_ready` in READY with `inflight`=0 -> `err`=1, `err_code`=2, `res_valid` stays 0.
